// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: writeback source selects and load types.
package mips_pkg;
    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_LINK = 2'b10;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;
endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a little-endian data word and extends it to 32 bits.
module load_extend
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ldtype,
    output logic [31:0] value
);
    logic [7:0]  lane [4];
    logic [15:0] half [2];
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    // Halfword loads ignore addr_lo[0]; misalignment is not trapped here.
    assign sel_b = lane[addr_lo];
    assign sel_h = half[addr_lo[1]];

    always_comb begin
        value = rdata;
        case (ldtype)
            LD_LB:   value = {{24{sel_b[7]}}, sel_b};
            LD_LBU:  value = {24'd0, sel_b};
            LD_LH:   value = {{16{sel_h[15]}}, sel_h};
            LD_LHU:  value = {16'd0, sel_h};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback driver for the register file, with same-cycle bypass flags.
module wb_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_regwr,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wbsel,
    input  logic [2:0]       mem_ldtype,
    input  logic [1:0]       mem_addr_lo,
    input  logic [31:0]      mem_alu,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      mem_pc8,
    input  logic [4:0]       id_A,
    input  logic [4:0]       id_B,
    output logic [4:0]       rf_W,
    output logic [31:0]      rf_din,
    output logic             rf_RFWr,
    output logic             fwd_A,
    output logic             fwd_B,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired
);
    logic             valid_reg;
    logic             regwr_reg;
    logic [4:0]       rd_reg;
    logic [31:0]      data_reg;
    logic             done_reg;
    logic [CNT_W-1:0] retired_reg;
    logic [31:0]      load_val;
    logic [31:0]      data_next;

    load_extend u_load_extend (
        .rdata   (mem_rdata),
        .addr_lo (mem_addr_lo),
        .ldtype  (mem_ldtype),
        .value   (load_val)
    );

    always_comb begin
        data_next = mem_alu;
        case (mem_wbsel)
            WBSEL_LOAD: data_next = load_val;
            WBSEL_LINK: data_next = mem_pc8;
            default:    data_next = mem_alu;
        endcase
    end

    // done marks an entry that has already committed while being held by a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            regwr_reg <= 1'b0;
            rd_reg    <= 5'd0;
            data_reg  <= 32'd0;
            done_reg  <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else if (stall) begin
            if (valid_reg)
                done_reg <= 1'b1;
        end else begin
            valid_reg <= mem_valid;
            regwr_reg <= mem_regwr;
            rd_reg    <= mem_rd;
            data_reg  <= data_next;
            done_reg  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_reg <= '0;
        else if (valid_reg && !done_reg)
            retired_reg <= retired_reg + CNT_W'(1);
    end

    // rf does not protect $0, so writes to it are suppressed here.
    assign rf_RFWr  = valid_reg & regwr_reg & (rd_reg != 5'd0) & ~done_reg;
    assign rf_W     = rd_reg;
    assign rf_din   = data_reg;
    assign fwd_A    = rf_RFWr & (id_A == rd_reg);
    assign fwd_B    = rf_RFWr & (id_B == rd_reg);
    assign wb_valid = valid_reg;
    assign retired  = retired_reg;
endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU, loads, $0 guard, stall, link, flush and reset.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_regwr;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_ldtype;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu, mem_rdata, mem_pc8;
    logic [4:0]  id_A, id_B;
    logic [4:0]  rf_W;
    logic [31:0] rf_din;
    logic        rf_RFWr, fwd_A, fwd_B, wb_valid;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;
    logic [31:0] rf_model [32];

    wb_stage #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwr(mem_regwr), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_ldtype(mem_ldtype), .mem_addr_lo(mem_addr_lo),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata), .mem_pc8(mem_pc8),
        .id_A(id_A), .id_B(id_B), .rf_W(rf_W), .rf_din(rf_din), .rf_RFWr(rf_RFWr),
        .fwd_A(fwd_A), .fwd_B(fwd_B), .wb_valid(wb_valid), .retired(retired)
    );

    always #5 clk = ~clk;

    // Register file as the write side sees it; cleared by the same reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_model[i] <= 32'd0;
        end else if (rf_RFWr) begin
            rf_model[rf_W] <= rf_din;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; mem_valid = 0; mem_regwr = 0; mem_rd = 0;
        mem_wbsel = 2'b00; mem_ldtype = 3'b000; mem_addr_lo = 2'b00;
        mem_alu = 0; mem_rdata = 0; mem_pc8 = 0; id_A = 0; id_B = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        checks++;
        if (rf_RFWr !== 1'b0 || rf_W !== 5'd0 || rf_din !== 32'd0 || wb_valid !== 1'b0 ||
            fwd_A !== 1'b0 || fwd_B !== 1'b0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL reset: RFWr=%b W=%0d din=%h valid=%b fA=%b fB=%b ret=%0d, need all 0",
                     rf_RFWr, rf_W, rf_din, wb_valid, fwd_A, fwd_B, retired);
        end
        $display("reset: RFWr=%b W=%0d din=%h ret=%0d", rf_RFWr, rf_W, rf_din, retired);
    endtask

    task automatic test_alu();
        mem_valid = 1; mem_regwr = 1; mem_rd = 5; mem_wbsel = 2'b00; mem_alu = 32'h1234_5678;
        id_A = 4; id_B = 5;
        step();
        exp_ret++;
        checks++;
        if (rf_RFWr !== 1'b1 || rf_W !== 5'd5 || rf_din !== 32'h1234_5678) begin
            errors++;
            $display("FAIL alu: RFWr=%b W=%0d din=%h, need 1 5 12345678", rf_RFWr, rf_W, rf_din);
        end
        checks++;
        if (fwd_A !== 1'b0 || fwd_B !== 1'b1) begin
            errors++;
            $display("FAIL alu_fwd: fA=%b fB=%b, need 0 1", fwd_A, fwd_B);
        end
        // wbsel=11 behaves as ALU
        mem_rd = 6; mem_wbsel = 2'b11; mem_alu = 32'hCAFE_0001; mem_pc8 = 32'h1111_1111;
        step();
        exp_ret++;
        checks++;
        if (rf_din !== 32'hCAFE_0001 || rf_W !== 5'd6) begin
            errors++;
            $display("FAIL wbsel11: din=%h W=%0d, need cafe0001 6", rf_din, rf_W);
        end
        mem_valid = 0; mem_regwr = 0;
        step();
        checks++;
        if (rf_model[5] !== 32'h1234_5678 || rf_model[6] !== 32'hCAFE_0001 || retired !== exp_ret) begin
            errors++;
            $display("FAIL alu_commit: rf5=%h rf6=%h ret=%0d, need 12345678 cafe0001 %0d",
                     rf_model[5], rf_model[6], retired, exp_ret);
        end
        $display("alu: rf5=%h rf6=%h ret=%0d", rf_model[5], rf_model[6], retired);
    endtask

    task automatic test_loads();
        logic [2:0]  lt [5];
        logic [1:0]  lo [5];
        logic [31:0] ex [5];
        lt[0] = 3'b001; lo[0] = 2; ex[0] = 32'hFFFF_FFFF;
        lt[1] = 3'b010; lo[1] = 3; ex[1] = 32'h0000_0080;
        lt[2] = 3'b011; lo[2] = 2; ex[2] = 32'hFFFF_80FF;
        lt[3] = 3'b100; lo[3] = 1; ex[3] = 32'h0000_7F01;
        lt[4] = 3'b000; lo[4] = 3; ex[4] = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1; mem_regwr = 1; mem_rd = 3; mem_wbsel = 2'b01;
            mem_rdata = 32'h80FF_7F01; mem_alu = 32'h5555_5555;
            mem_ldtype = lt[i]; mem_addr_lo = lo[i];
            step();
            exp_ret++;
            checks++;
            if (rf_din !== ex[i] || rf_RFWr !== 1'b1) begin
                errors++;
                $display("FAIL load%0d: din=%h RFWr=%b, need %h 1", i, rf_din, rf_RFWr, ex[i]);
            end
            $display("load ldtype=%0d lo=%0d: din=%h", lt[i], lo[i], rf_din);
        end
        mem_valid = 0; mem_regwr = 0;
        step();
    endtask

    task automatic test_reg0();
        mem_valid = 1; mem_regwr = 1; mem_rd = 0; mem_wbsel = 2'b00; mem_alu = 32'h0000_DEAD;
        id_A = 0; id_B = 0;
        step();
        exp_ret++;
        checks++;
        if (rf_RFWr !== 1'b0 || fwd_A !== 1'b0 || fwd_B !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg0: RFWr=%b fA=%b fB=%b valid=%b, need 0 0 0 1", rf_RFWr, fwd_A, fwd_B, wb_valid);
        end
        mem_valid = 0; mem_regwr = 0;
        step();
        checks++;
        if (rf_model[0] !== 32'd0 || retired !== exp_ret) begin
            errors++;
            $display("FAIL reg0_commit: rf0=%h ret=%0d, need 0 %0d", rf_model[0], retired, exp_ret);
        end
        $display("reg0: rf0=%h ret=%0d", rf_model[0], retired);
    endtask

    task automatic test_stall();
        int wr_cycles = 0;
        mem_valid = 1; mem_regwr = 1; mem_rd = 7; mem_wbsel = 2'b00; mem_alu = 32'h0000_0777;
        step();
        exp_ret++;
        if (rf_RFWr === 1'b1) wr_cycles++;
        stall = 1; mem_rd = 9; mem_alu = 32'h9999_9999;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rf_RFWr === 1'b1) wr_cycles++;
        end
        checks++;
        if (wr_cycles !== 1 || rf_W !== 5'd7 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: wr_cycles=%0d W=%0d valid=%b, need 1 7 1", wr_cycles, rf_W, wb_valid);
        end
        stall = 0; mem_valid = 0; mem_regwr = 0;
        step();
        checks++;
        if (retired !== exp_ret || rf_model[7] !== 32'h0000_0777) begin
            errors++;
            $display("FAIL stall_count: ret=%0d rf7=%h, need %0d 00000777", retired, rf_model[7], exp_ret);
        end
        $display("stall: wr_cycles=%0d ret=%0d", wr_cycles, retired);
    endtask

    task automatic test_link();
        mem_valid = 1; mem_regwr = 1; mem_rd = 31; mem_wbsel = 2'b10;
        mem_pc8 = 32'h0040_0008; mem_alu = 32'hBAD0_BAD0; id_A = 31; id_B = 30;
        step();
        exp_ret++;
        checks++;
        if (fwd_A !== 1'b1 || fwd_B !== 1'b0 || rf_din !== 32'h0040_0008 || rf_W !== 5'd31) begin
            errors++;
            $display("FAIL link: fA=%b fB=%b din=%h W=%0d, need 1 0 00400008 31", fwd_A, fwd_B, rf_din, rf_W);
        end
        mem_valid = 0; mem_regwr = 0;
        step();
        $display("link: din=%h rf31=%h", rf_din, rf_model[31]);
    endtask

    task automatic test_flush_reset();
        mem_valid = 1; mem_regwr = 1; mem_rd = 12; mem_wbsel = 2'b00; mem_alu = 32'h0000_00C0;
        step();
        exp_ret++;
        flush = 1; stall = 1;
        step();
        checks++;
        if (wb_valid !== 1'b0 || rf_RFWr !== 1'b0 || retired !== exp_ret || rf_model[12] !== 32'h0000_00C0) begin
            errors++;
            $display("FAIL flush_stall: valid=%b RFWr=%b ret=%0d rf12=%h, need 0 0 %0d 000000c0",
                     wb_valid, rf_RFWr, retired, exp_ret, rf_model[12]);
        end
        flush = 0; stall = 0; mem_rd = 13; mem_alu = 32'h0000_0D00;
        step();
        #2;
        rst = 1;
        #1;
        checks++;
        if (rf_RFWr !== 1'b0 || rf_W !== 5'd0 || rf_din !== 32'd0 || wb_valid !== 1'b0 ||
            fwd_A !== 1'b0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL async_rst: RFWr=%b W=%0d din=%h valid=%b fA=%b ret=%0d, need all 0",
                     rf_RFWr, rf_W, rf_din, wb_valid, fwd_A, retired);
        end
        mem_valid = 0; mem_regwr = 0;
        step();
        rst = 0;
        step();
        checks++;
        if (rf_model[13] !== 32'd0 || retired !== 32'd0) begin
            errors++;
            $display("FAIL rst_drop: rf13=%h ret=%0d, need 0 0", rf_model[13], retired);
        end
        $display("flush/reset: valid=%b ret=%0d", wb_valid, retired);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_reg0();
        test_stall();
        test_link();
        test_flush_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
